dff_pipe: RTL and testbench

- Parametrised elastic pipeline register: DEPTH chained N-bit register stages with valid/ready handshake.
- Successor to the plain register primitives; drop-in for timing-cut insertion on CPU datapaths (fetch→decode, LSU→bus).
- Each stage is a 2-entry skid buffer, so ready is fully registered and throughput is 1 beat/cycle under backpressure.

---
 rtl/dff_pkg.sv | 15 +
 rtl/dff_pipe_stage.sv | 102 ++++++++++
 rtl/dff_pipe.sv | 83 ++++++++
 tb/tb_dff_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared types and helpers for the dff_pipe elastic pipeline register.
package dff_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } stage_t;

  // Width needed to hold 0..2*depth beats.
  function automatic int count_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// Single 2-entry skid stage: main reg M is the head, skid reg S holds the second beat.
// Optional synchronous flush when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int           N    = 32,
  parameter logic [N-1:0] INIT = {N{1'b0}}
) (
  input  logic         C,
  input  logic         R,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  // state | meaning
  // EMPTY | no beat held, M stale
  // BUSY  | one beat in M
  // FULL  | two beats, M is older, S is younger; upstream stalled
  stage_t       r_state;
  stage_t       w_state_nxt;
  logic [N-1:0] r_m;
  logic [N-1:0] r_s;
  logic         w_acc;
  logic         w_drn;
  logic         w_load_m;
  logic         w_load_s;
  logic         w_m_from_s;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_m;
  assign w_acc     = in_valid && in_ready;
  assign w_drn     = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    w_load_s    = 1'b0;
    w_m_from_s  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt = BUSY;
          w_load_m    = 1'b1;
        end
      end
      BUSY: begin
        if (w_acc && !w_drn) begin
          w_state_nxt = FULL;
          w_load_s    = 1'b1;
        end else if (!w_acc && w_drn) begin
          w_state_nxt = EMPTY;
        end else if (w_acc && w_drn) begin
          w_load_m    = 1'b1;
        end
      end
      FULL: begin
        if (w_drn) begin
          w_state_nxt = BUSY;
          w_load_m    = 1'b1;
          w_m_from_s  = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
`ifdef DFF_PIPE_FLUSH_EN
    // Flush wins over any handshake; data regs keep their contents.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_load_m    = 1'b0;
      w_load_s    = 1'b0;
      w_m_from_s  = 1'b0;
    end
`endif
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_m <= INIT;
      r_s <= INIT;
    end else begin
      if (w_load_m) r_m <= w_m_from_s ? r_s : in_data;
      if (w_load_s) r_s <= in_data;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic pipeline register: DEPTH chained skid stages with a registered beat count.
// Optional synchronous flush port when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int           N     = 32,
  parameter int           DEPTH = 1,
  parameter logic [N-1:0] INIT  = {N{1'b0}}
) (
  input  logic                        C,
  input  logic                        R,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        in_valid,
  input  logic [N-1:0]                in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [N-1:0]                out_data,
  input  logic                        out_ready,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int            CW      = count_w(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * DEPTH);

  logic [DEPTH:0] w_v;
  logic [DEPTH:0] w_r;
  logic [N-1:0]   w_d [0:DEPTH];
  logic [CW-1:0]  r_count;
  logic           w_in_fire;
  logic           w_out_fire;

  assign w_v[0]     = in_valid;
  assign w_d[0]     = in_data;
  assign in_ready   = w_r[0];
  assign out_valid  = w_v[DEPTH];
  assign out_data   = w_d[DEPTH];
  assign w_r[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_pipe_stage #(
      .N    (N),
      .INIT (INIT)
    ) u_stage (
      .C         (C),
      .R         (R),
`ifdef DFF_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (w_v[g]),
      .in_data   (w_d[g]),
      .in_ready  (w_r[g]),
      .out_valid (w_v[g+1]),
      .out_data  (w_d[g+1]),
      .out_ready (w_r[g+1])
    );
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_count <= '0;
`ifdef DFF_PIPE_FLUSH_EN
    end else if (flush) begin
      r_count <= '0;
`endif
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

  a_count_max: assert property (@(posedge C) disable iff (!R) r_count <= CNT_MAX);

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (N=8, DEPTH=3): directed vectors plus a queue-based model.
module tb_dff_pipe;
  localparam int           N     = 8;
  localparam int           DEPTH = 3;
  localparam logic [N-1:0] INIT  = 8'h5A;
  localparam int           CW    = $clog2(2 * DEPTH + 1);

  logic          C = 1'b0;
  logic          R = 1'b0;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          fl_sig;
`ifdef DFF_PIPE_FLUSH_EN
  logic          flush;
  assign fl_sig = flush;
`else
  assign fl_sig = 1'b0;
`endif

  always #5 C = ~C;

  dff_pipe #(.N(N), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .C         (C),
    .R         (R),
`ifdef DFF_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Model: a FIFO of beats in flight; the head must surface within DEPTH-1
  // edges of becoming the oldest beat, and must hold while stalled.
  logic [N-1:0] q[$];
  int           head_age   = 0;
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_data  = '0;

  always @(negedge C) begin
    if (!R) begin
      q.delete();
      head_age   = 0;
      prev_stall = 1'b0;
    end else begin
      logic fin, fout, popped, was_empty;
      check("count", 32'(count), 32'(q.size()));
      if (q.size() == 0) check("out_valid idle", 32'(out_valid), 0);
      else if (head_age >= DEPTH - 1) check("out_valid due", 32'(out_valid), 1);
      if (out_valid && q.size() > 0) check("out_data head", 32'(out_data), 32'(q[0]));
      if (q.size() < 2) check("in_ready room", 32'(in_ready), 1);
      if (prev_stall) begin
        check("stall valid", 32'(out_valid), 1);
        check("stall data", 32'(out_data), 32'(prev_data));
      end
      fin       = in_valid && in_ready;
      fout      = out_valid && out_ready;
      popped    = 1'b0;
      was_empty = (q.size() == 0);
      if (fl_sig) begin
        q.delete();
      end else begin
        if (fout && q.size() > 0) begin
          void'(q.pop_front());
          popped = 1'b1;
        end
        if (fin) q.push_back(in_data);
      end
      if (popped || (was_empty && q.size() > 0)) head_age = 0;
      else head_age++;
      prev_stall = !fl_sig && out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    logic took;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
    flush     = 1'b0;
`endif
    R = 1'b0;
    repeat (2) tick();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst count", 32'(count), 0);
    check("rst out_data", 32'(out_data), 32'h5A);
    R = 1'b1;

    // Streaming 0x01..0x10, beat k accepted at edge k, visible after edge k+2.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("stream valid", 32'(out_valid), 32'(k >= 3 && k <= 18));
      if (k >= 3 && k <= 18) check("stream data", 32'(out_data), 32'(k - 2));
      check("stream in_ready", 32'(in_ready), 1);
      in_valid = (k < 16);
      in_data  = 8'(k + 1);
    end

    // Backpressure fill: capacity is 2*DEPTH = 6.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h20;
    acc      = 0;
    for (int k = 0; k < 12; k++) begin
      took = in_ready;
      if (took) acc++;
      tick();
      if (took) in_data = in_data + 8'h01;
    end
    check("fill accepted", 32'(acc), 6);
    check("fill in_ready", 32'(in_ready), 0);
    check("fill count", 32'(count), 6);
    check("fill head", 32'(out_data), 32'h20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 1; d <= 7; d++) begin
      tick();
      check("drain in_ready", 32'(in_ready), 32'(d >= 3));
      check("drain valid", 32'(out_valid), 32'(d <= 5));
      if (d <= 5) check("drain data", 32'(out_data), 32'(8'h20 + d));
    end

    // Simultaneous in/out transfer at count=2.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h40;
    tick();
    in_data = 8'h41;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("simul pre count", 32'(count), 2);
    check("simul pre valid", 32'(out_valid), 1);
    check("simul pre data", 32'(out_data), 32'h40);
    check("simul pre ready", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = 8'h42;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("simul count", 32'(count), 2);
    check("simul data", 32'(out_data), 32'h41);
    repeat (8) tick();
    check("simul drained", 32'(count), 0);

    // Random stall traffic; the model process does the checking.
    for (int k = 0; k < 10000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset while the pipe holds beats.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    check("pre-reset count nonzero", 32'(count != 0), 1);
    #1;
    R = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 0);
    check("async rst in_ready", 32'(in_ready), 1);
    check("async rst count", 32'(count), 0);
    check("async rst out_data", 32'(out_data), 32'h5A);
    in_valid = 1'b0;
    tick();
    R = 1'b1;
    tick();

`ifdef DFF_PIPE_FLUSH_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h60;
    repeat (5) begin
      tick();
      in_data = in_data + 8'h01;
    end
    in_valid = 1'b0;
    check("flush pre count", 32'(count), 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush count", 32'(count), 0);
    check("flush out_valid", 32'(out_valid), 0);
    check("flush in_ready", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("post-flush valid", 32'(out_valid), 1);
    check("post-flush data", 32'(out_data), 32'h77);
`endif

    out_ready = 1'b1;
    repeat (10) tick();
    check("final count", 32'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
